// File: rtl/i2so_pkg.sv
// Shared types for the I2S-out sample FIFO: default sample width,
// control state encoding and the stored stereo pair layout.
package i2so_pkg;

  localparam int I2S_DATA_W = 16;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } i2so_state_e;

  typedef struct packed {
    logic [I2S_DATA_W-1:0] lft;
    logic [I2S_DATA_W-1:0] rgt;
  } i2so_pair_t;

endpackage

// File: rtl/i2so_fifo_mem.sv
// Register-array storage for the sample FIFO: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module i2so_fifo_mem #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];

  // Write the addressed entry on a qualified write strobe.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/i2so_sample_fifo.sv
// Stereo sample FIFO between the filter and the I2S-out serializer.
// Holds the serializer off until START_LEVEL pairs are stored, then stays
// in RUN and answers underruns with a zero pair. Overflow/underrun are sticky.
module i2so_sample_fifo
  import i2so_pkg::*;
#(
  parameter int DATA_W      = I2S_DATA_W,
  parameter int DEPTH_LOG2  = 3,
  parameter int START_LEVEL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                filt_fifo_push,
  input  logic [DATA_W-1:0]   filt_fifo_lft,
  input  logic [DATA_W-1:0]   filt_fifo_rgt,
  output logic                fifo_filt_full,
  output logic                filt_i2so_rts,
  input  logic                filt_i2so_rtr,
  output logic [DATA_W-1:0]   filt_i2so_lft,
  output logic [DATA_W-1:0]   filt_i2so_rgt,
  output logic [DEPTH_LOG2:0] fifo_level,
  output logic                fifo_ovf,
  output logic                fifo_udf
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] START_LVL = PW'(START_LEVEL);

  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                ovf_q;
  logic                udf_q;
  logic                rts_q;
  i2so_state_e         state_q;

  logic                empty;
  logic                full;
  logic [PW-1:0]       level;
  logic                pop_req;
  logic                pop_ok;
  logic                push_ok;
  logic                ovf_set;
  logic                udf_set;
  logic [2*DATA_W-1:0] rdata;

  // Pointer MSB distinguishes a full buffer from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                 (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
  assign level = wr_ptr_q - rd_ptr_q;

  // Pops are only honoured once streaming; an empty pop consumes the zero pair.
  assign pop_req = filt_i2so_rtr && (state_q == RUN);
  assign pop_ok  = pop_req && !empty;
  assign udf_set = pop_req && empty;

  // A pop in the same cycle frees the slot a push into a full buffer needs.
  assign push_ok = filt_fifo_push && (!full || pop_ok);
  assign ovf_set = filt_fifo_push && full && !pop_ok;

  assign wr_ptr_d = wr_ptr_q + PW'(1);
  assign rd_ptr_d = rd_ptr_q + PW'(1);

  i2so_fifo_mem #(
    .WIDTH  (2*DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_ok && !clr),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i ({filt_fifo_lft, filt_fifo_rgt}),
    .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rdata_o (rdata)
  );

  // Pointers, sticky flags and the PRIME/RUN state machine with registered rts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rts_q    <= 1'b0;
      state_q  <= PRIME;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rts_q    <= 1'b0;
      state_q  <= PRIME;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_d;
      if (pop_ok)  rd_ptr_q <= rd_ptr_d;
      if (ovf_set) ovf_q    <= 1'b1;
      if (udf_set) udf_q    <= 1'b1;
      case (state_q)
        PRIME: begin
          if (level >= START_LVL) begin
            state_q <= RUN;
            rts_q   <= 1'b1;
          end
        end
        RUN: begin
          // Stay streaming through underruns; only clr/rst leave RUN.
          rts_q <= 1'b1;
        end
        default: begin
          state_q <= PRIME;
          rts_q   <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_filt_full = full;
  assign filt_i2so_rts  = rts_q;
  assign fifo_level     = level;
  assign fifo_ovf       = ovf_q;
  assign fifo_udf       = udf_q;
  assign filt_i2so_lft  = empty ? '0 : rdata[2*DATA_W-1:DATA_W];
  assign filt_i2so_rgt  = empty ? '0 : rdata[DATA_W-1:0];

endmodule

// File: tb/tb_i2so_sample_fifo.sv
// Directed bench for i2so_sample_fifo: prefill, drain order, underrun,
// overflow, simultaneous push/pop, flush and asynchronous reset.
module tb_i2so_sample_fifo;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        push;
  logic [15:0] lft;
  logic [15:0] rgt;
  logic        full;
  logic        rts;
  logic        rtr;
  logic [15:0] hl;
  logic [15:0] hr;
  logic [3:0]  level;
  logic        ovf;
  logic        udf;

  int n_cmp = 0;
  int n_bad = 0;

  i2so_sample_fifo #(.DATA_W(16), .DEPTH_LOG2(3), .START_LEVEL(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .filt_fifo_push (push),
    .filt_fifo_lft  (lft),
    .filt_fifo_rgt  (rgt),
    .fifo_filt_full (full),
    .filt_i2so_rts  (rts),
    .filt_i2so_rtr  (rtr),
    .filt_i2so_lft  (hl),
    .filt_i2so_rgt  (hr),
    .fifo_level     (level),
    .fifo_ovf       (ovf),
    .fifo_udf       (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are applied at a falling edge and held for one rising edge;
  // on return the outputs reflect that edge and are stable for checking.
  task automatic step(input logic p, input logic [15:0] l, input logic [15:0] r,
                      input logic rd);
    push = p; lft = l; rgt = r; rtr = rd;
    @(negedge clk);
    push = 1'b0; rtr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_rts"},   32'(rts),   32'd0);
    chk({tag, "_full"},  32'(full),  32'd0);
    chk({tag, "_ovf"},   32'(ovf),   32'd0);
    chk({tag, "_udf"},   32'(udf),   32'd0);
    chk({tag, "_head"},  {hl, hr},   32'h0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; push = 1'b0; rtr = 1'b0; lft = '0; rgt = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_cleared("reset");

    // Prefill: rts must wait until level 4 has been seen for a cycle.
    step(1'b1, 16'h1111, 16'hAAAA, 1'b0);
    chk("pf1_level", 32'(level), 32'd1);
    chk("pf1_head", {hl, hr}, 32'h1111AAAA);
    step(1'b1, 16'h2222, 16'hBBBB, 1'b0);
    step(1'b1, 16'h3333, 16'hCCCC, 1'b0);
    chk("pf3_rts", 32'(rts), 32'd0);
    step(1'b1, 16'h4444, 16'hDDDD, 1'b0);
    chk("pf4_level", 32'(level), 32'd4);
    chk("pf4_rts", 32'(rts), 32'd0);
    idle(1);
    chk("pf_rts_up", 32'(rts), 32'd1);
    chk("pf_head", {hl, hr}, 32'h1111AAAA);

    // Drain order, pops 32 cycles apart.
    chk("dr0_head", {hl, hr}, 32'h1111AAAA);
    step(1'b0, 16'h0, 16'h0, 1'b1); idle(31);
    chk("dr1_head", {hl, hr}, 32'h2222BBBB);
    step(1'b0, 16'h0, 16'h0, 1'b1); idle(31);
    chk("dr2_head", {hl, hr}, 32'h3333CCCC);
    step(1'b0, 16'h0, 16'h0, 1'b1); idle(31);
    chk("dr3_head", {hl, hr}, 32'h4444DDDD);
    step(1'b0, 16'h0, 16'h0, 1'b1); idle(31);
    chk("dr_empty_head", {hl, hr}, 32'h0);
    chk("dr_empty_level", 32'(level), 32'd0);
    chk("dr_empty_rts", 32'(rts), 32'd1);
    chk("dr_udf_clear", 32'(udf), 32'd0);

    // Underrun: zero pair consumed, pointers unchanged, still streaming.
    step(1'b0, 16'h0, 16'h0, 1'b1);
    chk("udf_flag", 32'(udf), 32'd1);
    chk("udf_level", 32'(level), 32'd0);
    chk("udf_rts", 32'(rts), 32'd1);
    chk("udf_head", {hl, hr}, 32'h0);
    step(1'b1, 16'h7777, 16'h8888, 1'b0);
    chk("udf_ptr_head", {hl, hr}, 32'h77778888);
    chk("udf_ptr_level", 32'(level), 32'd1);

    // Flush clears flags and returns to PRIME.
    clr = 1'b1; step(1'b0, 16'h0, 16'h0, 1'b0); clr = 1'b0;
    chk_cleared("clr1");

    // Overflow: 9 pushes, the 9th dropped.
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 16'h1000 + 16'(k), 16'h2000 + 16'(k), 1'b0);
      if (k == 8) begin
        chk("ovf_full8", 32'(full), 32'd1);
        chk("ovf_flag8", 32'(ovf), 32'd0);
      end
    end
    chk("ovf_flag9", 32'(ovf), 32'd1);
    chk("ovf_level9", 32'(level), 32'd8);
    chk("ovf_rts", 32'(rts), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("ovf_drain%0d", k), {hl, hr},
          {16'h1000 + 16'(k), 16'h2000 + 16'(k)});
      step(1'b0, 16'h0, 16'h0, 1'b1);
    end
    chk("ovf_drained_head", {hl, hr}, 32'h0);
    chk("ovf_drained_level", 32'(level), 32'd0);

    // Push + pop at empty in RUN: underrun plus a stored pair.
    step(1'b1, 16'h5555, 16'h6666, 1'b1);
    chk("se_udf", 32'(udf), 32'd1);
    chk("se_level", 32'(level), 32'd1);
    chk("se_head", {hl, hr}, 32'h55556666);

    clr = 1'b1; step(1'b0, 16'h0, 16'h0, 1'b0); clr = 1'b0;
    chk_cleared("clr2");

    // Push + pop at full: both succeed, no overflow.
    for (int k = 1; k <= 8; k++) step(1'b1, 16'h3000 + 16'(k), 16'h4000 + 16'(k), 1'b0);
    chk("sf_full", 32'(full), 32'd1);
    step(1'b1, 16'h3009, 16'h4009, 1'b1);
    chk("sf_level", 32'(level), 32'd8);
    chk("sf_ovf", 32'(ovf), 32'd0);
    chk("sf_head", {hl, hr}, 32'h30024002);

    // Flush mid-stream at level 5, with a push and pop also requested.
    step(1'b0, 16'h0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b1);
    chk("fl_level5", 32'(level), 32'd5);
    clr = 1'b1; step(1'b1, 16'h9999, 16'h9999, 1'b1); clr = 1'b0;
    chk_cleared("clr3");

    // PRIME ignores rtr; refill needs START_LEVEL pushes again.
    step(1'b1, 16'hA001, 16'hB001, 1'b0);
    step(1'b1, 16'hA002, 16'hB002, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1);
    chk("pr_rtr_level", 32'(level), 32'd2);
    chk("pr_rtr_udf", 32'(udf), 32'd0);
    chk("pr_rtr_head", {hl, hr}, 32'hA001B001);
    step(1'b1, 16'hA003, 16'hB003, 1'b0);
    idle(1);
    chk("rf3_rts", 32'(rts), 32'd0);
    step(1'b1, 16'hA004, 16'hB004, 1'b0);
    chk("rf4_rts", 32'(rts), 32'd0);
    idle(1);
    chk("rf4_rts_up", 32'(rts), 32'd1);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1 chk_cleared("arst");
    @(negedge clk);
    rst = 1'b0;
    chk_cleared("arst_rel");
    for (int k = 1; k <= 3; k++) step(1'b1, 16'hC000 + 16'(k), 16'hD000 + 16'(k), 1'b0);
    idle(1);
    chk("ar3_rts", 32'(rts), 32'd0);
    chk("ar3_head", {hl, hr}, 32'hC001D001);
    step(1'b1, 16'hC004, 16'hD004, 1'b0);
    idle(1);
    chk("ar4_rts", 32'(rts), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
